// File: rtl/display_scan_controller_if.sv
// Display scan controller bus: frame update handshake, scan enable,
// blink select and the multiplexed active-low 7-segment outputs.
interface display_scan_controller_if;
  logic        EN;
  logic        UPD_REQ;
  logic        UPD_ACK;
  logic [15:0] D_IN;
  logic [3:0]  DP_IN;
  logic [3:0]  BLINK_MASK;
  logic [6:0]  SEG;
  logic [3:0]  DIG;
  logic        DP;

  // Requester / panel side
  modport master (
    output EN, UPD_REQ, D_IN, DP_IN, BLINK_MASK,
    input  UPD_ACK, SEG, DIG, DP
  );

  // Scan controller side
  modport slave (
    input  EN, UPD_REQ, D_IN, DP_IN, BLINK_MASK,
    output UPD_ACK, SEG, DIG, DP
  );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller.
// Frames are snapshotted through a req/ack handshake only at frame
// boundaries (or immediately while scanning is disabled) so a digit
// sequence never mixes two frames. Each digit slot starts with a blank
// gap to suppress ghosting. All outputs are registered, active-low.
// Optional blink feature: define DISPLAY_BLINK_EN.
module display_scan_controller #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input logic                         CLK,
  input logic                         RST,
  display_scan_controller_if.slave    bus
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  // Hex code to active-low glyph, SEG[6]=a ... SEG[0]=g
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  logic [CW-1:0] cnt_q,      cnt_d;
  logic [1:0]    idx_q,      idx_d;
  logic [15:0]   frame_d_q,  frame_d_d;
  logic [3:0]    frame_dp_q, frame_dp_d;
  logic          ack_q,      ack_d;
  logic [6:0]    seg_q,      seg_d;
  logic [3:0]    dig_q,      dig_d;
  logic          dp_q,       dp_d;

  logic last_slot;
  logic boundary;
  logic blank;
  logic blink_hide;

  assign last_slot = (cnt_q == CNT_LAST);
  assign boundary  = last_slot && (idx_q == 2'd3);
  assign blank     = (cnt_q < BLANK_END);

`ifdef DISPLAY_BLINK_EN
  localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q,  blink_on_d;

  // Count frame boundaries and flip the blink phase every BLINK_FRAMES
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (bus.EN && boundary) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink counter and phase registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_hide = !blink_on_q && bus.BLINK_MASK[idx_q];
`else
  logic unused_blink;
  assign unused_blink = ^{bus.BLINK_MASK, 1'(BLINK_FRAMES & 1)};
  assign blink_hide   = 1'b0;
`endif

  // Scan sequencing, output decode and frame capture
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    frame_d_d  = frame_d_q;
    frame_dp_d = frame_dp_q;
    ack_d      = 1'b0;
    seg_d      = 7'h7F;
    dig_d      = 4'hF;
    dp_d       = 1'b1;

    if (!bus.EN) begin
      cnt_d = '0;
      idx_d = 2'd0;
      // Idle display: take a frame as soon as it is offered
      ack_d = bus.UPD_REQ && !ack_q;
    end else begin
      if (!blank) begin
        dig_d = ~(4'b0001 << idx_q);
        seg_d = hex_to_seg(frame_d_q[{idx_q, 2'b00} +: 4]);
        dp_d  = ~frame_dp_q[idx_q];
        if (blink_hide) begin
          seg_d = 7'h7F;
          dp_d  = 1'b1;
        end
      end
      if (last_slot) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // Scanning display: only swap frames between digit 3 and digit 0
      ack_d = boundary && bus.UPD_REQ;
    end

    if (ack_d) begin
      frame_d_d  = bus.D_IN;
      frame_dp_d = bus.DP_IN;
    end
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (RST) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      frame_d_q  <= 16'h0000;
      frame_dp_q <= 4'h0;
      ack_q      <= 1'b0;
      seg_q      <= 7'h7F;
      dig_q      <= 4'hF;
      dp_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      frame_d_q  <= frame_d_d;
      frame_dp_q <= frame_dp_d;
      ack_q      <= ack_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.UPD_ACK = ack_q;
  assign bus.SEG     = seg_q;
  assign bus.DIG     = dig_q;
  assign bus.DP      = dp_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Testbench for display_scan_controller (CLK_DIV=4, BLANK_CYCLES=1).
// A time-based reference model (cycles since scanning started) predicts
// every registered output; directed scenarios add explicit checks.
module tb_display_scan_controller;
  localparam int CLK_DIV      = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  display_scan_controller_if bus ();

  display_scan_controller #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model state
  int         m_t;      // cycles since scanning (re)started
  int         m_nb;     // frame boundaries seen since reset
  logic [15:0] m_fd;
  logic [3:0]  m_fdp;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_dig;
  logic        exp_dp;
  logic        exp_ack;
  int          m_pos, m_digit;
  bit          m_nack;

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_nb = 0; m_fd = 16'h0; m_fdp = 4'h0;
      exp_seg = 7'h7F; exp_dig = 4'hF; exp_dp = 1'b1; exp_ack = 1'b0;
    end else begin
      m_nack  = 1'b0;
      exp_seg = 7'h7F; exp_dig = 4'hF; exp_dp = 1'b1;
      if (!bus.EN) begin
        m_t = 0;
        if (bus.UPD_REQ && !exp_ack) begin
          m_fd = bus.D_IN; m_fdp = bus.DP_IN; m_nack = 1'b1;
        end
      end else begin
        m_pos   = m_t % CLK_DIV;
        m_digit = (m_t / CLK_DIV) % 4;
        if (m_pos >= BLANK_CYCLES) begin
          exp_dig[m_digit] = 1'b0;
          exp_seg = glyph[m_fd[m_digit*4 +: 4]];
          exp_dp  = !m_fdp[m_digit];
`ifdef DISPLAY_BLINK_EN
          if (((m_nb / BLINK_FRAMES) % 2 == 1) && bus.BLINK_MASK[m_digit]) begin
            exp_seg = 7'h7F; exp_dp = 1'b1;
          end
`endif
        end
        if (m_t % FRAME == FRAME - 1) begin
          m_nb++;
          if (bus.UPD_REQ) begin
            m_fd = bus.D_IN; m_fdp = bus.DP_IN; m_nack = 1'b1;
          end
        end
        m_t++;
      end
      exp_ack = m_nack;
    end
  end

  task automatic test_reset;
    bus.EN = 1'b0; bus.UPD_REQ = 1'b0; bus.D_IN = 16'h0; bus.DP_IN = 4'h0;
    bus.BLINK_MASK = 4'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL reset: seg=%b dig=%b dp=%b ack=%b expected 1111111/1111/1/0",
               bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan;
    logic [3:0] want_dig;
    bus.EN = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      compared++;
      if ({bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK} !== {exp_seg, exp_dig, exp_dp, exp_ack}) begin
        mismatched++;
        $display("FAIL scan_model c=%0d: got %b/%b/%b/%b expected %b/%b/%b/%b", c,
                 bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK, exp_seg, exp_dig, exp_dp, exp_ack);
      end
      want_dig = (c % 4 == 0) ? 4'hF : ~(4'b0001 << ((c % 16) / 4));
      compared++;
      if (bus.DIG !== want_dig || (want_dig != 4'hF && bus.SEG !== 7'b0000001)) begin
        mismatched++;
        $display("FAIL scan_pattern c=%0d: dig=%b seg=%b expected dig=%b seg=0000001",
                 c, bus.DIG, bus.SEG, want_dig);
      end
    end
  endtask

  task automatic test_update;
    int acks = 0;
    int after = -1;
    logic [7:0] want;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      compared++;
      if ({bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK} !== {exp_seg, exp_dig, exp_dp, exp_ack}) begin
        mismatched++;
        $display("FAIL update_model c=%0d: got %b/%b/%b/%b expected %b/%b/%b/%b", c,
                 bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK, exp_seg, exp_dig, exp_dp, exp_ack);
      end
      if (after >= 0 && after < 16) begin
        case (bus.DIG)
          4'b1110: want = {7'b0000001, 1'b1};
          4'b1101: want = {7'b0111000, 1'b0};
          4'b1011: want = {7'b0000000, 1'b1};
          4'b0111: want = {7'b1001111, 1'b1};
          4'b1111: want = {7'h7F, 1'b1};
          default: want = 8'hxx;
        endcase
        compared++;
        if ({bus.SEG, bus.DP} !== want) begin
          mismatched++;
          $display("FAIL update_frame dig=%b: seg/dp=%b expected %b", bus.DIG, {bus.SEG, bus.DP}, want);
        end
        after++;
      end
      if (bus.UPD_ACK) begin
        acks++;
        bus.UPD_REQ = 1'b0;
        after = 0;
      end
      if (c == 5) begin
        bus.D_IN = 16'h18F0; bus.DP_IN = 4'b0010; bus.UPD_REQ = 1'b1;
      end
    end
    compared++;
    if (acks !== 1) begin
      mismatched++;
      $display("FAIL update_ack_count: got %0d expected 1", acks);
    end
  endtask

  task automatic test_drop;
    int acks = 0;
    int c = 0;
    while (m_t % FRAME != 2 && c < 40) begin
      @(negedge clk);
      c++;
    end
    bus.D_IN = 16'hFFFF; bus.DP_IN = 4'hF; bus.UPD_REQ = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK} !== {exp_seg, exp_dig, exp_dp, exp_ack}) begin
        mismatched++;
        $display("FAIL drop_model k=%0d: got %b/%b/%b/%b expected %b/%b/%b/%b", k,
                 bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK, exp_seg, exp_dig, exp_dp, exp_ack);
      end
      if (bus.UPD_ACK) acks++;
      if (k == 1) bus.UPD_REQ = 1'b0;
    end
    compared++;
    if (acks !== 0) begin
      mismatched++;
      $display("FAIL drop_no_ack: got %0d acks expected 0", acks);
    end
  endtask

  task automatic test_en;
    int c = 0;
    logic [15:0] d = 16'($urandom);
    while (bus.DIG !== 4'b1011 && c < 40) begin
      @(negedge clk);
      c++;
    end
    compared++;
    if (bus.DIG !== 4'b1011) begin
      mismatched++;
      $display("FAIL en_wait_slot2: dig=%b expected 1011 within 40 cycles", bus.DIG);
    end
    bus.EN = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.SEG, bus.DIG} !== {7'h7F, 4'hF}) begin
      mismatched++;
      $display("FAIL en_dark: seg=%b dig=%b expected 1111111/1111", bus.SEG, bus.DIG);
    end
    bus.D_IN = d; bus.DP_IN = 4'b0001; bus.UPD_REQ = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.UPD_ACK !== 1'b1 || exp_ack !== 1'b1) begin
      mismatched++;
      $display("FAIL en_idle_ack: ack=%b expected 1", bus.UPD_ACK);
    end
    bus.UPD_REQ = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL en_idle_after_ack: got %b/%b/%b/%b expected 1111111/1111/1/0",
               bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK);
    end
    bus.EN = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.DIG !== 4'hF) begin
      mismatched++;
      $display("FAIL en_resume_blank: dig=%b expected 1111", bus.DIG);
    end
    @(negedge clk);
    compared++;
    if ({bus.DIG, bus.SEG, bus.DP} !== {4'b1110, glyph[d[3:0]], 1'b0}) begin
      mismatched++;
      $display("FAIL en_resume_digit0: dig/seg/dp=%b/%b/%b expected 1110/%b/0",
               bus.DIG, bus.SEG, bus.DP, glyph[d[3:0]]);
    end
  endtask

  task automatic test_rst_mid;
    int c = 0;
    while (m_t % FRAME != 6 && c < 40) begin
      @(negedge clk);
      c++;
    end
    bus.D_IN = 16'h1234; bus.DP_IN = 4'hF; bus.UPD_REQ = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL rst_mid: got %b/%b/%b/%b expected 1111111/1111/1/0",
               bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK);
    end
    bus.UPD_REQ = 1'b0; bus.EN = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    bus.EN = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK} !== {exp_seg, exp_dig, exp_dp, exp_ack}) begin
        mismatched++;
        $display("FAIL rst_model k=%0d: got %b/%b/%b/%b expected %b/%b/%b/%b", k,
                 bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK, exp_seg, exp_dig, exp_dp, exp_ack);
      end
      compared++;
      if (bus.DIG !== 4'hF && {bus.SEG, bus.DP} !== {7'b0000001, 1'b1}) begin
        mismatched++;
        $display("FAIL rst_frame_zero k=%0d: seg=%b dp=%b expected 0000001/1", k, bus.SEG, bus.DP);
      end
    end
  endtask

  task automatic test_random;
    bus.EN = 1'b1;
    bus.BLINK_MASK = 4'b0001;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK} !== {exp_seg, exp_dig, exp_dp, exp_ack}) begin
        mismatched++;
        $display("FAIL random_model k=%0d: got %b/%b/%b/%b expected %b/%b/%b/%b", k,
                 bus.SEG, bus.DIG, bus.DP, bus.UPD_ACK, exp_seg, exp_dig, exp_dp, exp_ack);
      end
      rst = ($urandom_range(0, 399) == 0);
      if (rst || bus.UPD_ACK) begin
        bus.UPD_REQ = 1'b0;
      end else if (bus.UPD_REQ && $urandom_range(0, 29) == 0) begin
        bus.UPD_REQ = 1'b0;
      end else if (!bus.UPD_REQ && $urandom_range(0, 19) == 0) begin
        bus.D_IN = 16'($urandom); bus.DP_IN = 4'($urandom); bus.UPD_REQ = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) bus.EN = ~bus.EN;
      if (k >= 1500 && $urandom_range(0, 299) == 0) bus.BLINK_MASK = 4'($urandom);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_update();
    test_drop();
    test_en();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes one shared 7-segment bus (SEG/DP) across 4 common digits (DIG) of the controller's front-panel display.
- Snapshots a 16-bit frame of four 4-bit hex codes through a req/ack handshake, but only at frame boundaries, so the display never tears.
- Scans digits 0→3 with a programmable slot time and an anti-ghosting blank gap.
- Drives the same active-low SEG/DIG/DP pin convention as the existing segment decoders.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot; legal range ≥2.
- BLANK_CYCLES, 1000: blank cycles at the start of each slot; legal range 0..CLK_DIV-1.
- BLINK_FRAMES, 64: full frames per blink half-period; only used with the blink feature.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  scan enable; low = display dark.
- UPD_REQ  input  1  frame update request (level).
- UPD_ACK  output  1  one-cycle pulse: frame captured.
- D_IN  input  16  hex codes; [3:0] = digit 0 … [15:12] = digit 3.
- DP_IN  input  4  decimal point per digit, active-high; captured with D_IN.
- BLINK_MASK  input  4  per-digit blink select; sampled live, not captured.
- SEG  output  7  segments, active-low; SEG[6]=a … SEG[0]=g.
- DIG  output  4  digit enables, active-low; DIG[i] selects digit i.
- DP  output  1  decimal point, active-low.

Behaviour:
- Clock and reset:
  - One clock, CLK. RST is synchronous and active-high.
  - RST clears all state: slot counter=0, digit index=0, frame regs D=0/DP=0, UPD_ACK=0, blink phase=on.
  - Reset values of outputs: SEG=7'h7F, DIG=4'hF, DP=1, UPD_ACK=0.
  - RST asserted mid-handshake drops the pending request. The requester must re-request.
- State: slot counter CNT (0..CLK_DIV-1), digit index IDX (0..3), frame regs.
- Phase per cycle: BLANK when CNT<BLANK_CYCLES, else SHOW.
- Counter advance: at CNT=CLK_DIV-1, CNT→0 and IDX→IDX+1, wrapping 3→0. Frame boundary = CNT=CLK_DIV-1 with IDX=3.
- Outputs are registered. The value driven in cycle n reflects CNT/IDX/phase of cycle n-1.
  - BLANK phase: SEG=7'h7F, DIG=4'hF, DP=1.
  - SHOW phase: DIG = only bit IDX low; SEG = decode(frame digit IDX); DP = ~frame DP[IDX].
- Decode, active-low:
  - Standard hex glyphs 0-9, A, b, C, d, E, F.
  - Examples: 0→7'b0000001, 1→7'b1001111, 8→7'b0000000, F→7'b0111000.
- Update handshake:
  - Requester raises UPD_REQ with D_IN/DP_IN stable and holds them until UPD_ACK.
  - With EN=1: capture happens only on the frame-boundary cycle with UPD_REQ=1. UPD_ACK pulses the next cycle. New data is shown from slot 0 of the next frame.
  - With EN=0: capture happens on the first cycle UPD_REQ=1. UPD_ACK follows next cycle.
  - UPD_REQ dropped before the boundary: no capture, no ack.
  - UPD_ACK never stays high for 2 consecutive cycles. The requester must drop UPD_REQ the cycle after ack; a request still high then is not re-captured until the next boundary.
- EN handling:
  - EN=0 holds CNT=0, IDX=0. Outputs go dark next cycle.
  - EN 0→1 resumes scanning at CNT=0, IDX=0, BLANK phase first.
- BLANK_CYCLES=0: no blank phase; DIG changes directly between adjacent digits.

Optional Feature:
- Macro: DISPLAY_BLINK_EN.
- Defined:
  - A frame counter toggles the blink phase every BLINK_FRAMES frame boundaries.
  - During the off half, digits with BLINK_MASK[IDX]=1 show SEG=7'h7F and DP=1 in SHOW phase. DIG still scans.
  - Blink counter and phase are reset by RST and held while EN=0.
- Undefined: BLINK_MASK is ignored; no frame counter logic is synthesized.

Test Plan:
- Bench config for all scenarios: CLK_DIV=4, BLANK_CYCLES=1.
- Reset then EN=1, frame regs 0 → per slot: 1 cycle DIG=4'hF, then 3 cycles DIG=4'b1110, then 4'b1101, 4'b1011, 4'b0111, repeating; SEG=7'b0000001 in SHOW cycles; period 16 cycles.
- UPD_REQ=1 with D_IN=16'h18F0 and DP_IN=4'b0010, raised mid-frame → exactly one UPD_ACK pulse, 1 cycle after the boundary. Next frame SEG = 0000001 (digit 0), 0111000 (digit 1), 0000000 (digit 2), 1001111 (digit 3). DP=0 only while DIG=4'b1101.
- UPD_REQ pulsed 2 cycles and dropped before the boundary → no UPD_ACK; display unchanged.
- EN=0 during slot 2 → next cycle SEG=7'h7F, DIG=4'hF. UPD_REQ=1 while EN=0 → UPD_ACK 1 cycle later. EN=1 → blank cycle, then digit 0.
- RST asserted mid-slot with UPD_REQ pending → next cycle outputs at reset values, no UPD_ACK. Frame regs show 0 after EN restart.
- DISPLAY_BLINK_EN with BLINK_FRAMES=2, BLINK_MASK=4'b0001 → digit 0 SEG alternates glyph / 7'h7F every 2 frames; digits 1-3 unaffected.
